exc_seq: RTL and testbench
==========================

# exc_seq

Exception/interrupt sequencer for the five-stage MIPS pipeline. It carries per-stage exception codes down to the M stage with oldest-first priority and presents a single code, victim PC and delay-slot flag to the CP0 block. When CP0 signals a taken interrupt/exception, or an ERET reaches M, it flushes the pipeline, redirects fetch and drives CP0's EXL set/clear strobes. It sits between the hazard unit, the pipeline registers, the NPC mux and CP0.

## Interface
- HANDLER_PC, 32'h0000_4180, handler entry address
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard-unit stall: F/D frozen, bubble into E
- exc_f  in  5  exception code raised in F (0 = none)
- exc_d  in  5  exception code raised in D
- exc_e  in  5  exception code raised in E
- pc_m  in  32  PC of instruction in M
- bd_m  in  1  M instruction is in a branch delay slot
- eret_m  in  1  M instruction is ERET
- int_req  in  1  CP0 Interrupt output (taken request)
- epc  in  32  CP0 EPC output
- exc_code_m  out  5  code presented to CP0 ExcCode
- cp0_pc  out  32  victim PC presented to CP0
- cp0_bd  out  1  delay-slot flag presented to CP0
- exl_set  out  1  CP0 EXL set strobe
- exl_clr  out  1  CP0 EXL clear strobe
- flush  out  1  clear F/D/E/M pipeline registers this edge
- redirect  out  1  NPC override valid
- redirect_pc  out  32  NPC override target
- busy  out  1  state != RUN
- exc_count  out  16  saturating count of taken entries

## Operation
- Code pipeline registers code_d, code_e, code_m (5 b each). Per edge, when not flushing:
  - code_d <= stall ? code_d : exc_f
  - code_e <= stall ? 0 : (code_d != 0 ? code_d : exc_d)
  - code_m <= code_e != 0 ? code_e : exc_e
  - Older code always wins. A younger code never overwrites it.
- exc_code_m = code_m in RUN. It is forced to 0 in HOLD.
- cp0_bd = bd_m. cp0_pc = {pc_m[31:2],2'b00} - (bd_m ? 4 : 0), with 32-bit wrap.
- FSM states are RUN and HOLD.
  - RUN, int_req=1: this is a take. Outputs are exl_set=1, flush=1, redirect=1, redirect_pc=HANDLER_PC. exc_count increments, saturating at 16'hFFFF. Next state is HOLD.
  - RUN, int_req=0, eret_m=1: this is a return. Outputs are exl_clr=1, flush=1, redirect=1, redirect_pc={epc[31:2],2'b00}. Next state is HOLD.
  - RUN, otherwise: all strobes are 0. State stays RUN.
  - HOLD: all strobes are 0 and int_req/eret_m are ignored. Next state is RUN unconditionally.
- Flush clears code_d/e/m to 0 on the same edge. Flush has priority over stall.
- When int_req and eret_m are high together, the take wins. The ERET is discarded: no exl_clr, and no EPC redirect.

## Timing
- All strobes (exl_set, exl_clr, flush, redirect, redirect_pc) are combinational from state and inputs in the same cycle. They are not registered.
- An exception raised in stage X reaches exc_code_m 3/2/1 edges later for X = F/D/E, plus any stall cycles for F.
- Take/return occupies exactly 2 cycles: the action cycle plus HOLD. busy=1 only in HOLD.
- Reset values: state RUN, code_d/e/m 0, exc_count 0. All outputs are 0 except cp0_pc/cp0_bd, which follow their inputs.
- Reset asserted in HOLD returns the FSM to RUN on the next edge. Strobes are suppressed while reset=1.

## Test plan
- exc_f=5'd4 for one cycle, no stall, int_req wired to (exc_code_m!=0): exc_code_m=4 three edges later. In that cycle flush=1, redirect_pc=0x4180, exl_set=1. Next cycle busy=1, exc_code_m=0. exc_count=1.
- exc_d=10 and exc_e=12 raised for the same instruction pair: the older code 10 reaches M first. The take flushes, and 12 never reaches exc_code_m.
- pc_m=0x3010, bd_m=1, take: cp0_pc=0x300C, cp0_bd=1. With bd_m=0: cp0_pc=0x3010.
- eret_m=1, epc=0x3024, int_req=0: exl_clr=1, flush=1, redirect_pc=0x3024. Repeat with int_req=1: redirect_pc=0x4180, exl_clr=0.
- exc_f=4 with stall held 2 cycles: code stays in D during the stall, and the E bubble carries 0. exc_code_m=4 arrives two cycles later than in the first test.
- Force 65535 takes then 1 more: exc_count stays 16'hFFFF. Reset asserted in HOLD: the next cycle is RUN, and exc_count=0.

Source files
------------

// File: rtl/exc_seq.sv
// Exception/interrupt sequencer: carries stage exception codes to M (oldest first) and drives the CP0 handshake.
// Strobes are combinational from the current state; take/return occupies the action cycle plus one HOLD cycle.
module exc_seq #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [4:0]  exc_f,
    input  logic [4:0]  exc_d,
    input  logic [4:0]  exc_e,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        eret_m,
    input  logic        int_req,
    input  logic [31:0] epc,
    output logic [4:0]  exc_code_m,
    output logic [31:0] cp0_pc,
    output logic        cp0_bd,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [15:0] exc_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_code_d;
    logic [4:0]  r_code_e;
    logic [4:0]  r_code_m;
    logic [15:0] r_exc_count;
    logic        w_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A take outranks an ERET sitting in M in the same cycle; the ERET is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        exl_set     = 1'b0;
        exl_clr     = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        case (r_state)
            RUN: begin
                if (!reset) begin
                    if (int_req) begin
                        w_take      = 1'b1;
                        exl_set     = 1'b1;
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = HANDLER_PC;
                        w_state_nxt = HOLD;
                    end else if (eret_m) begin
                        exl_clr     = 1'b1;
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = epc & 32'hFFFF_FFFC;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // An older instruction's code is carried forward in preference to anything raised later.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_code_d <= 5'd0;
            r_code_e <= 5'd0;
            r_code_m <= 5'd0;
        end else begin
            r_code_d <= stall ? r_code_d : exc_f;
            r_code_e <= stall ? 5'd0 : ((r_code_d != 5'd0) ? r_code_d : exc_d);
            r_code_m <= (r_code_e != 5'd0) ? r_code_e : exc_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exc_count <= 16'd0;
        end else if (w_take && (r_exc_count != 16'hFFFF)) begin
            r_exc_count <= r_exc_count + 16'd1;
        end
    end

    assign exc_code_m = (r_state == RUN) ? r_code_m : 5'd0;
    assign cp0_bd     = bd_m;
    assign cp0_pc     = (pc_m & 32'hFFFF_FFFC) - (bd_m ? 32'd4 : 32'd0);
    assign busy       = (r_state == HOLD);
    assign exc_count  = r_exc_count;

endmodule

// File: tb/tb_exc_seq.sv
// Randomized and directed scoreboard bench for exc_seq against an instruction-level reference model.
module tb_exc_seq;

    localparam logic [31:0] HPC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [4:0]  exc_f = 5'd0, exc_d = 5'd0, exc_e = 5'd0;
    logic [31:0] pc_m = 32'd0, epc = 32'd0;
    logic        bd_m = 1'b0, eret_m = 1'b0, int_req = 1'b0;
    logic [4:0]  exc_code_m;
    logic [31:0] cp0_pc, redirect_pc;
    logic        cp0_bd, exl_set, exl_clr, flush, redirect, busy;
    logic [15:0] exc_count;

    exc_seq #(.HANDLER_PC(HPC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .exc_f(exc_f), .exc_d(exc_d), .exc_e(exc_e),
        .pc_m(pc_m), .bd_m(bd_m), .eret_m(eret_m), .int_req(int_req), .epc(epc),
        .exc_code_m(exc_code_m), .cp0_pc(cp0_pc), .cp0_bd(cp0_bd),
        .exl_set(exl_set), .exl_clr(exl_clr), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .busy(busy), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] cpc;
        logic        bd, set, clr, fl, rd;
        logic [31:0] rpc;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic        rst, st, bd, er, ir, au;
        logic [4:0]  f, d, e;
        logic [31:0] pc, ep;
    } in_t;

    exp_t q[$];
    exp_t mon_e, mon_a;
    in_t  nx;
    int   total = 0;
    int   bad = 0;

    // Reference: code carried by the instruction currently in D, E, M; sequencer busy flag; entry count.
    logic [4:0] ins_d = 5'd0, ins_e = 5'd0, ins_m = 5'd0;
    bit         m_hold = 1'b0;
    int         mcnt = 0;

    function automatic logic [4:0] oldest(input logic [4:0] older, input logic [4:0] younger);
        return (older != 5'd0) ? older : younger;
    endfunction

    task automatic model_cycle();
        exp_t e;
        bit take, ret;
        take = !reset && !m_hold && int_req;
        ret  = !reset && !m_hold && !int_req && eret_m;
        e.code = m_hold ? 5'd0 : ins_m;
        e.cpc  = {pc_m[31:2], 2'b00} - (bd_m ? 32'd4 : 32'd0);
        e.bd   = bd_m;
        e.set  = take;
        e.clr  = ret;
        e.fl   = take || ret;
        e.rd   = take || ret;
        e.rpc  = take ? HPC : (ret ? {epc[31:2], 2'b00} : 32'd0);
        e.busy = m_hold;
        e.cnt  = 16'(mcnt);
        q.push_back(e);
        if (reset) begin
            m_hold = 1'b0; mcnt = 0;
            ins_d = 5'd0; ins_e = 5'd0; ins_m = 5'd0;
        end else begin
            m_hold = take || ret;
            if (take && mcnt < 65535) mcnt = mcnt + 1;
            if (take || ret) begin
                ins_d = 5'd0; ins_e = 5'd0; ins_m = 5'd0;
            end else begin
                ins_m = oldest(ins_e, exc_e);
                ins_e = stall ? 5'd0 : oldest(ins_d, exc_d);
                ins_d = stall ? ins_d : exc_f;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        reset = nx.rst; stall = nx.st;
        exc_f = nx.f; exc_d = nx.d; exc_e = nx.e;
        pc_m = nx.pc; bd_m = nx.bd; eret_m = nx.er; epc = nx.ep;
        int_req = nx.au ? (!m_hold && ins_m != 5'd0) : nx.ir;
        model_cycle();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            mon_a = {exc_code_m, cp0_pc, cp0_bd, exl_set, exl_clr, flush, redirect,
                     redirect_pc, busy, exc_count};
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, mon_a, mon_e);
            end
        end
    end

    initial begin
        nx = '{rst: 1'b1, st: 1'b0, bd: 1'b0, er: 1'b0, ir: 1'b0, au: 1'b0,
               f: 5'd0, d: 5'd0, e: 5'd0, pc: 32'h0000_3000, ep: 32'd0};
        cyc(); cyc();
        #1 chk("reset_count", 32'(exc_count), 0);
        chk("reset_flush", 32'(flush), 0);
        nx.rst = 1'b0;
        cyc();

        // F-stage code reaches M three edges later and is taken.
        nx.f = 5'd4; cyc();
        nx.f = 5'd0; nx.au = 1'b1;
        cyc(); cyc(); cyc();
        #1 chk("f_code_m", 32'(exc_code_m), 4);
        chk("f_flush", 32'(flush), 1);
        chk("f_redirect_pc", redirect_pc, HPC);
        chk("f_exl_set", 32'(exl_set), 1);
        cyc();
        #1 chk("f_busy", 32'(busy), 1);
        chk("f_hold_code", 32'(exc_code_m), 0);
        chk("f_count", 32'(exc_count), 1);
        cyc();

        // Older D code beats younger E code; the take flushes the younger one.
        nx.d = 5'd10; cyc();
        nx.d = 5'd0; nx.e = 5'd12; cyc(); cyc();
        #1 chk("de_code_m", 32'(exc_code_m), 10);
        chk("de_flush", 32'(flush), 1);
        nx.e = 5'd0; cyc(); cyc();
        #1 chk("de_no_12", 32'(exc_code_m), 0);

        // Victim PC with and without the delay slot.
        nx.au = 1'b0; nx.ir = 1'b1; nx.pc = 32'h0000_3010; nx.bd = 1'b1; cyc();
        #1 chk("bd_cp0_pc", cp0_pc, 32'h0000_300C);
        chk("bd_cp0_bd", 32'(cp0_bd), 1);
        nx.ir = 1'b0; cyc();
        nx.bd = 1'b0; cyc();
        #1 chk("nobd_cp0_pc", cp0_pc, 32'h0000_3010);

        // ERET alone returns to EPC; with int_req the take wins.
        nx.er = 1'b1; nx.ep = 32'h0000_3024; cyc();
        #1 chk("eret_clr", 32'(exl_clr), 1);
        chk("eret_flush", 32'(flush), 1);
        chk("eret_pc", redirect_pc, 32'h0000_3024);
        nx.er = 1'b0; cyc();
        nx.er = 1'b1; nx.ir = 1'b1; cyc();
        #1 chk("eret_int_pc", redirect_pc, HPC);
        chk("eret_int_clr", 32'(exl_clr), 0);
        nx.er = 1'b0; nx.ir = 1'b0; cyc();

        // Two stall cycles delay the F code by two edges.
        nx.au = 1'b1; cyc();
        nx.f = 5'd4; cyc();
        nx.f = 5'd0; nx.st = 1'b1; cyc(); cyc();
        nx.st = 1'b0; cyc(); cyc();
        #1 chk("stall_early", 32'(exc_code_m), 0);
        cyc();
        #1 chk("stall_code_m", 32'(exc_code_m), 4);
        nx.au = 1'b0; cyc(); cyc();

        // Counter saturation.
        @(negedge clk); #1;
        force dut.r_exc_count = 16'hFFFE;
        #1 release dut.r_exc_count;
        mcnt = 65534;
        nx.ir = 1'b1; cyc();
        nx.ir = 1'b0; cyc();
        #1 chk("sat_first", 32'(exc_count), 32'hFFFF);
        nx.ir = 1'b1; cyc();
        nx.ir = 1'b0; cyc();
        #1 chk("sat_hold", 32'(exc_count), 32'hFFFF);

        // Reset while in HOLD.
        nx.ir = 1'b1; cyc();
        nx.ir = 1'b1; nx.rst = 1'b1; cyc();
        #1 chk("rst_hold_busy", 32'(busy), 1);
        chk("rst_hold_set", 32'(exl_set), 0);
        nx.ir = 1'b0; nx.rst = 1'b0; cyc();
        #1 chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(exc_count), 0);

        repeat (4000) begin
            nx.rst = ($urandom_range(0, 199) == 0);
            nx.st  = ($urandom_range(0, 3) == 0);
            nx.f   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            nx.d   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            nx.e   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            nx.pc  = $urandom;
            nx.ep  = $urandom;
            nx.bd  = 1'($urandom_range(0, 1));
            nx.er  = ($urandom_range(0, 7) == 0);
            nx.au  = 1'($urandom_range(0, 1));
            nx.ir  = ($urandom_range(0, 9) == 0);
            cyc();
        end

        nx.rst = 1'b0; nx.er = 1'b0; nx.ir = 1'b0; nx.au = 1'b0;
        cyc();
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
